uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a UART transmit FIFO. Owns the grant for a
// whole packet, alternates ownership on contention and revokes an idle grant.
module uart_tx_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       last0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  input  logic       last1,
  output logic       ack1,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       grant0,
  output logic       grant1,
  output logic       timeout_evt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        prio_reg, prio_next;     // 1 favours channel 1 on contention
  logic [15:0] idle_cnt_reg, idle_cnt_next;

  logic req_sel;
  logic last_sel;
  logic xfer;
  logic timeout_hit;

  // View of the channel that currently owns the UART; all zero in IDLE.
  always_comb begin
    req_sel  = 1'b0;
    last_sel = 1'b0;
    case (state_reg)
      GNT0: begin
        req_sel  = req0;
        last_sel = last0;
      end
      GNT1: begin
        req_sel  = req1;
        last_sel = last1;
      end
      default: begin
        req_sel  = 1'b0;
        last_sel = 1'b0;
      end
    endcase
  end

  assign xfer        = req_sel && !tx_full;
  assign timeout_hit = (state_reg != IDLE) && !req_sel && (idle_cnt_reg == IDLE_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      prio_reg     <= 1'b0;
      idle_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      prio_reg     <= prio_next;
      idle_cnt_reg <= idle_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    prio_next     = prio_reg;
    idle_cnt_next = idle_cnt_reg;
    case (state_reg)
      IDLE: begin
        idle_cnt_next = '0;
        if (req0 && req1) begin
          state_next = prio_reg ? GNT1 : GNT0;
        end else if (req0) begin
          state_next = GNT0;
        end else if (req1) begin
          state_next = GNT1;
        end
      end
      GNT0, GNT1: begin
        // A stalled byte (tx_full) keeps req high, so it never counts as idle.
        if (req_sel) begin
          idle_cnt_next = '0;
        end else begin
          idle_cnt_next = idle_cnt_reg + 16'd1;
        end
        if ((xfer && last_sel) || timeout_hit) begin
          state_next = IDLE;
          prio_next  = (state_reg == GNT0);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    grant0      = (state_reg == GNT0);
    grant1      = (state_reg == GNT1);
    wr_uart     = xfer;
    ack0        = xfer && (state_reg == GNT0);
    ack1        = xfer && (state_reg == GNT1);
    timeout_evt = timeout_hit;
    case (state_reg)
      GNT0:    w_data = data0;
      GNT1:    w_data = data1;
      default: w_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: packet sources feed both channels,
// a monitor checks every FIFO write and records a per-cycle grant trace.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, last0 = 1'b0, req1 = 1'b0, last1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       tx_full = 1'b0;
  logic       ack0, ack1, wr_uart, grant0, grant1, timeout_evt;
  logic [7:0] w_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Source items: {gap, last, data}; a gap holds req low for one cycle.
  logic [9:0] src0_q[$];
  logic [9:0] src1_q[$];
  // Expected writes: {channel, data}.
  logic [8:0] exp_q[$];
  logic       ack0_s = 1'b0, ack1_s = 1'b0;
  string      trace = "";

  localparam logic [9:0] GAP = 10'h200;

  uart_tx_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(rst),
    .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .grant0(grant0), .grant1(grant1), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] byt(input logic [7:0] d, input logic l);
    return {1'b0, l, d};
  endfunction

  function automatic string tchar();
    if (grant0 && grant1) return "X";
    if (grant0) return timeout_evt ? "T" : "0";
    if (grant1) return timeout_evt ? "U" : "1";
    return timeout_evt ? "E" : ".";
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_trace(input string name, input string exp);
    n_checks++;
    if (trace == exp) n_pass++;
    else $display("FAIL %s: grant trace got \"%s\" expected \"%s\"", name, trace, exp);
  endtask

  task automatic push_both(input logic [9:0] item, input logic ch);
    if (ch) src1_q.push_back(item);
    else src0_q.push_back(item);
    if (!item[9]) exp_q.push_back({ch, item[7:0]});
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Source driver: retire the presented item, then present the next one.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        src0_q.delete();
        src1_q.delete();
      end else begin
        if (src0_q.size() > 0 && (src0_q[0][9] || ack0_s)) void'(src0_q.pop_front());
        if (src1_q.size() > 0 && (src1_q[0][9] || ack1_s)) void'(src1_q.pop_front());
      end
      #1;
      if (src0_q.size() > 0 && !src0_q[0][9]) begin
        req0 = 1'b1; data0 = src0_q[0][7:0]; last0 = src0_q[0][8];
      end else begin
        req0 = 1'b0; data0 = 8'h00; last0 = 1'b0;
      end
      if (src1_q.size() > 0 && !src1_q[0][9]) begin
        req1 = 1'b1; data1 = src1_q[0][7:0]; last1 = src1_q[0][8];
      end else begin
        req1 = 1'b0; data1 = 8'h00; last1 = 1'b0;
      end
    end
  end

  // Monitor: grant trace, per-cycle invariants, scoreboard on every write.
  initial begin
    logic [8:0] e;
    logic       ok;
    forever begin
      @(negedge clk);
      ack0_s = ack0;
      ack1_s = ack1;
      trace  = {trace, tchar()};
      ok = !(grant0 && grant1) && (wr_uart == (ack0 || ack1)) &&
           !(ack0 && !grant0) && !(ack1 && !grant1) && !(wr_uart && tx_full);
      check("invariants", {27'd0, grant0, grant1, ack0, ack1, wr_uart}, ok ? {27'd0, grant0, grant1, ack0, ack1, wr_uart} : 32'hFFFF_FFFF);
      if (wr_uart) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got ch%0d data %0h expected no write", ack1, w_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_byte", {23'd0, ack1, w_data}, {23'd0, e});
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {18'd0, grant0, grant1, timeout_evt, wr_uart, ack0, ack1, w_data}, 32'd0);
    rst = 1'b0;

    // Three-byte packet on channel 0
    trace = "";
    push_both(byt(8'h41, 1'b0), 1'b0);
    push_both(byt(8'h42, 1'b0), 1'b0);
    push_both(byt(8'h43, 1'b1), 1'b0);
    repeat (6) @(negedge clk);
    #1;
    check_trace("single_3byte", ".000..");
    check("drain_3byte", exp_q.size(), 0);

    // Simultaneous requests after reset: channel 0 first
    reset_dut();
    trace = "";
    push_both(byt(8'h10, 1'b0), 1'b0);
    push_both(byt(8'h11, 1'b1), 1'b0);
    push_both(byt(8'h20, 1'b0), 1'b1);
    push_both(byt(8'h21, 1'b1), 1'b1);
    repeat (8) @(negedge clk);
    #1;
    check_trace("simultaneous", ".00.11..");
    check("drain_simul", exp_q.size(), 0);

    // Continuous 1-byte packets alternate with an idle cycle between
    trace = "";
    for (int i = 0; i < 3; i++) begin
      push_both(byt(8'hA0 + 8'(i), 1'b1), 1'b0);
      push_both(byt(8'hB0 + 8'(i), 1'b1), 1'b1);
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 8'hA0 + 8'(i)});
      exp_q.push_back({1'b1, 8'hB0 + 8'(i)});
    end
    repeat (13) @(negedge clk);
    #1;
    check_trace("alternate", ".0.1.0.1.0.1.");
    check("drain_alt", exp_q.size(), 0);

    // FIFO full for 5 cycles during the 2nd byte of a channel 1 packet
    trace = "";
    push_both(byt(8'h30, 1'b0), 1'b1);
    push_both(byt(8'h31, 1'b0), 1'b1);
    push_both(byt(8'h32, 1'b1), 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    tx_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", {29'd0, grant1, wr_uart, ack1}, 32'b100);
      @(posedge clk);
      #1;
    end
    tx_full = 1'b0;
    @(negedge clk);
    check("stall_release", {23'd0, wr_uart, w_data}, {23'd0, 1'b1, 8'h31});
    repeat (2) @(negedge clk);
    #1;
    check_trace("stall", ".11111111.");
    check("drain_stall", exp_q.size(), 0);

    // Timeout: req0 drops after a non-last byte, req1 waiting
    trace = "";
    push_both(byt(8'h50, 1'b0), 1'b0);
    repeat (6) push_both(GAP, 1'b0);
    push_both(byt(8'h60, 1'b1), 1'b1);
    repeat (9) @(negedge clk);
    #1;
    check_trace("timeout", ".0000T.1.");
    check("drain_timeout", exp_q.size(), 0);

    // Reset while channel 1 is mid-packet
    trace = "";
    push_both(byt(8'h70, 1'b0), 1'b1);
    src1_q.push_back(byt(8'h71, 1'b0));
    src1_q.push_back(byt(8'h72, 1'b1));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    check("pre_reset_xfer", {23'd0, wr_uart, w_data}, {23'd0, 1'b1, 8'h71});
    rst = 1'b1;
    #1;
    check("reset_mid_req", {31'd0, req1}, 32'd1);
    check("reset_mid_outputs", {18'd0, grant0, grant1, timeout_evt, wr_uart, ack0, ack1, w_data}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_hold_outputs", {18'd0, grant0, grant1, timeout_evt, wr_uart, ack0, ack1, w_data}, 32'd0);
    rst = 1'b0;
    trace = "";
    push_both(byt(8'h80, 1'b1), 1'b0);
    push_both(byt(8'h90, 1'b1), 1'b1);
    repeat (5) @(negedge clk);
    #1;
    check_trace("post_reset", ".0.1.");
    check("drain_post_reset", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
